mem_responder: RTL and testbench

Synthesizable single-port word memory acting as the responder end of the processor's val/rdy memory request/response interface. It serves instruction or data traffic for processor test harnesses and FPGA bring-up. Latency is configurable, and a credit-limited response queue keeps it from dropping responses under back-pressure. A side load port lets a harness preload programs and data before releasing the processor.

---
 rtl/mem_responder_pkg.sv | 21 ++
 rtl/mem_resp_queue.sv | 56 +++++
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and opcodes for the mem_responder val/rdy memory port.
package mem_responder_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic MEM_OP_READ  = 1'b0;
   localparam logic MEM_OP_WRITE = 1'b1;

   typedef struct packed {
      logic              op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } mem_req_t;

   typedef struct packed {
      logic              op;
      logic [DATA_W-1:0] data;
   } mem_resp_t;

endpackage

// File: rtl/mem_resp_queue.sv
// Response FIFO with val/rdy on both ends; head reads as zero when empty.
module mem_resp_queue
   import mem_responder_pkg::*;
#(
   parameter int unsigned p_depth = 2,
   parameter type t_data = mem_resp_t,
   localparam int unsigned CW = $clog2(p_depth + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enq_val,
   output logic          enq_rdy,
   input  t_data         enq_data,
   output logic          deq_val,
   input  logic          deq_rdy,
   output t_data         deq_data,
   output logic [CW-1:0] count
);

   localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;

   t_data         buf_q [p_depth];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_enq;
   logic          do_deq;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
   endfunction

   assign enq_rdy  = (count < CW'(p_depth));
   assign deq_val  = (count != '0);
   assign deq_data = deq_val ? buf_q[rd_ptr] : '0;
   assign do_enq   = enq_val && enq_rdy;
   assign do_deq   = deq_val && deq_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_enq) wr_ptr <= next_ptr(wr_ptr);
         if (do_deq) rd_ptr <= next_ptr(rd_ptr);
         if (do_enq && !do_deq)      count <= count + CW'(1);
         else if (!do_enq && do_deq) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq) buf_q[wr_ptr] <= enq_data;
   end

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory answering val/rdy requests through a credit-limited
// response queue. Define MEM_RESPONDER_RAND_STALL_EN for LFSR response stalls.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned p_num_words  = 256,
   parameter int unsigned p_latency    = 1,
   parameter int unsigned p_resp_depth = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_val,
   output logic        req_rdy,
   input  logic        req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic        resp_val,
   input  logic        resp_rdy,
   output logic        resp_op,
   output logic [31:0] resp_data,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);

   localparam int unsigned IW = $clog2(p_num_words);
   localparam int unsigned CW = $clog2(p_resp_depth + 1);
   localparam int unsigned SW = $clog2(p_latency + p_resp_depth + 1);

   logic [DATA_W-1:0] mem [p_num_words];

   mem_req_t  req;
   mem_resp_t acc_resp;
   mem_resp_t enq_resp;
   mem_resp_t head;
   logic          accept;
   logic          enq_val;
   logic          enq_rdy;
   logic          deq_val;
   logic          stall;
   logic [CW-1:0] count;
   logic [SW-1:0] inflight;
   logic          unused_bits;

   function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return a[2 +: IW];
   endfunction

   assign req    = '{op: req_op, addr: req_addr, data: req_data};
   assign accept = req_val && req_rdy;

   // Credits count every response already committed to a queue slot.
   assign req_rdy = !rst && !ld_en &&
                    ((inflight + SW'(count)) < SW'(p_resp_depth));

   // Preload has priority; req_rdy is low whenever ld_en is high.
   always_ff @(posedge clk) begin
      if (ld_en)                               mem[word_idx(ld_addr)]  <= ld_data;
      else if (accept && req.op == MEM_OP_WRITE) mem[word_idx(req.addr)] <= req.data;
   end

   always_comb begin
      acc_resp    = '0;
      acc_resp.op = req.op;
      if (req.op == MEM_OP_READ) acc_resp.data = mem[word_idx(req.addr)];
   end

   // The queue write is the final latency stage, so only p_latency-1 registers here.
   if (p_latency > 1) begin : g_pipe
      localparam int unsigned NS = p_latency - 1;
      logic [NS-1:0] pipe_val;
      mem_resp_t     pipe_resp [NS];

      always_ff @(posedge clk) begin
         if (rst) begin
            pipe_val <= '0;
         end else begin
            pipe_val[0] <= accept;
            for (int i = 1; i < int'(NS); i++) pipe_val[i] <= pipe_val[i-1];
         end
      end

      always_ff @(posedge clk) begin
         pipe_resp[0] <= acc_resp;
         for (int i = 1; i < int'(NS); i++) pipe_resp[i] <= pipe_resp[i-1];
      end

      assign enq_val  = pipe_val[NS-1];
      assign enq_resp = pipe_resp[NS-1];
      assign inflight = SW'($countones(pipe_val));
   end else begin : g_nopipe
      assign enq_val  = accept;
      assign enq_resp = acc_resp;
      assign inflight = '0;
   end

   mem_resp_queue #(
      .p_depth (p_resp_depth),
      .t_data  (mem_resp_t)
   ) u_queue (
      .clk      (clk),
      .rst      (rst),
      .enq_val  (enq_val),
      .enq_rdy  (enq_rdy),
      .enq_data (enq_resp),
      .deq_val  (deq_val),
      .deq_rdy  (resp_rdy && !stall),
      .deq_data (head),
      .count    (count)
   );

`ifdef MEM_RESPONDER_RAND_STALL_EN
   logic [7:0] lfsr;

   // Fibonacci LFSR, taps 8,6,5,4; stall pattern repeats identically after reset.
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 8'hA5;
      else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   assign resp_val  = deq_val && !stall;
   assign resp_op   = head.op;
   assign resp_data = head.data;

   // Enqueue can never be refused thanks to the credit rule.
   assign unused_bits = ^{enq_rdy, req_addr[31:IW+2], req_addr[1:0],
                          ld_addr[31:IW+2], ld_addr[1:0]};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: u_dut (latency 1, depth 2) and u_bp (latency 2, depth 2) share stimulus.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_val, req_op, resp_rdy, ld_en;
   logic [31:0] req_addr, req_data, ld_addr, ld_data;
   logic        req_rdy, resp_val, resp_op;
   logic [31:0] resp_data;
   logic        bp_req_rdy, bp_resp_val, bp_resp_op;
   logic [31:0] bp_resp_data;

   int total = 0;
   int bad   = 0;

   mem_responder #(.p_num_words(256), .p_latency(1), .p_resp_depth(2)) u_dut (
      .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data), .resp_val(resp_val), .resp_rdy(resp_rdy),
      .resp_op(resp_op), .resp_data(resp_data), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data)
   );

   mem_responder #(.p_num_words(256), .p_latency(2), .p_resp_depth(2)) u_bp (
      .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(bp_req_rdy), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data), .resp_val(bp_resp_val), .resp_rdy(resp_rdy),
      .resp_op(bp_resp_op), .resp_data(bp_resp_data), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic op, input logic [31:0] a,
                          input logic [31:0] d);
      req_val  = v;
      req_op   = op;
      req_addr = a;
      req_data = d;
   endtask

   logic [31:0] bp_addr [4];
   int          acc;

   initial begin
      rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; resp_rdy = 1'b1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Preload while reset is held
      ld_en = 1'b1; ld_addr = 32'h0;  ld_data = 32'h0000_0013; tick();
      ld_addr = 32'h14; ld_data = 32'hCAFE_0005;              tick();
      ld_en = 1'b0; #1;
      check_eq("rst_req_rdy",   32'(req_rdy),   32'h0);
      check_eq("rst_resp_val",  32'(resp_val),  32'h0);
      check_eq("rst_resp_op",   32'(resp_op),   32'h0);
      check_eq("rst_resp_data", resp_data,      32'h0);
      check_eq("rst_bp_val",    32'(bp_resp_val), 32'h0);
      rst = 1'b0; #1;
      check_eq("post_rst_rdy", 32'(req_rdy), 32'h1);

      // ld_en blocks requests
      ld_en = 1'b1; ld_addr = 32'h320; ld_data = 32'h0; #1;
      check_eq("ld_blocks_rdy", 32'(req_rdy), 32'h0);
      tick();
      ld_en = 1'b0; #1;
      check_eq("ld_release_rdy", 32'(req_rdy), 32'h1);

      // Preload then read
      set_req(1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("pre_val",  32'(resp_val), 32'h1);
      check_eq("pre_op",   32'(resp_op),  32'h0);
      check_eq("pre_data", resp_data,     32'h0000_0013);
      tick();
      check_eq("pre_drained", 32'(resp_val), 32'h0);

      // Write then read back-to-back
      set_req(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
      tick();
      set_req(1'b1, 1'b0, 32'h100, 32'h0);
      check_eq("wr_val",  32'(resp_val), 32'h1);
      check_eq("wr_op",   32'(resp_op),  32'h1);
      check_eq("wr_data", resp_data,     32'h0);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("raw_val",  32'(resp_val), 32'h1);
      check_eq("raw_op",   32'(resp_op),  32'h0);
      check_eq("raw_data", resp_data,     32'hDEAD_BEEF);
      tick();
      check_eq("raw_drained", 32'(resp_val), 32'h0);

      // Address wrap: 0x400 aliases word 0
      set_req(1'b1, 1'b1, 32'h400, 32'h1234_5678);
      tick();
      set_req(1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("wrap_op",   32'(resp_op), 32'h0);
      check_eq("wrap_data", resp_data,    32'h1234_5678);
      tick();

      // Reset mid-flight
      resp_rdy = 1'b0;
      set_req(1'b1, 1'b0, 32'h14, 32'h0);
      tick();
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0); #1;
      check_eq("mid_val_held", 32'(resp_val), 32'h1);
      check_eq("mid_no_credit", 32'(req_rdy), 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0; #1;
      check_eq("mid_rst_val",  32'(resp_val),   32'h0);
      check_eq("mid_rst_data", resp_data,       32'h0);
      check_eq("mid_rst_rdy",  32'(req_rdy),    32'h1);
      check_eq("mid_rst_bp",   32'(bp_resp_val), 32'h0);
      resp_rdy = 1'b1;
      set_req(1'b1, 1'b0, 32'h14, 32'h0);
      tick();
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("mid_mem_kept", resp_data, 32'hCAFE_0005);
      tick();
      tick();

      // Back-pressure on the latency-2 instance
      bp_addr[0] = 32'h100; bp_addr[1] = 32'h0; bp_addr[2] = 32'h14; bp_addr[3] = 32'h14;
      acc = 0;
      resp_rdy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         set_req(1'b1, 1'b0, bp_addr[acc % 4], 32'h0); #1;
         if (bp_req_rdy) acc++;
         tick();
      end
      set_req(1'b0, 1'b0, 32'h0, 32'h0); #1;
      check_eq("bp_accepted", 32'(acc),        32'd2);
      check_eq("bp_rdy_low",  32'(bp_req_rdy), 32'h0);
      check_eq("bp_head_val", 32'(bp_resp_val), 32'h1);
      check_eq("bp_head_0",   bp_resp_data,     32'hDEAD_BEEF);
      resp_rdy = 1'b1;
      tick();
      check_eq("bp_head_1_val", 32'(bp_resp_val), 32'h1);
      check_eq("bp_head_1",     bp_resp_data,     32'h1234_5678);
      tick();
      check_eq("bp_empty",  32'(bp_resp_val), 32'h0);
      check_eq("bp_rdy_up", 32'(bp_req_rdy),  32'h1);

      // Full throughput: preload words 0..15 under reset, then 16 back-to-back reads
      rst = 1'b1; ld_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ld_addr = 32'(i * 4);
         ld_data = 32'h1000_0000 + 32'(i);
         tick();
      end
      ld_en = 1'b0; rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         set_req(1'b1, 1'b0, 32'(i * 4), 32'h0); #1;
         check_eq($sformatf("tp_rdy_%0d", i), 32'(req_rdy), 32'h1);
         tick();
         check_eq($sformatf("tp_val_%0d", i),  32'(resp_val), 32'h1);
         check_eq($sformatf("tp_data_%0d", i), resp_data,     32'h1000_0000 + 32'(i));
      end
      set_req(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      check_eq("tp_drained", 32'(resp_val), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
